// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX result, formats load data and drives the WB/forwarding buses.
// Optional MEM_WAIT_EN macro adds a wait FSM plus hold register for SRAMs with a read-valid handshake.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [78:0] ex_to_mem_bus,
  input  logic [31:0] data_sram_rdata,
  input  logic        data_sram_rvalid,
  output logic [69:0] mem_to_wb_bus,
  output logic [37:0] mem_to_rf_bus,
  output logic        stallreq_for_mem
);

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic [2:0]  load_op;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LB  = 3'd1,
    OP_LBU = 3'd2,
    OP_LH  = 3'd3,
    OP_LHU = 3'd4
  } load_op_e;

  ex_mem_t     stage_q, stage_d;
  logic        is_load;
  logic        stall_req;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        rf_we;
  logic        unused_bits;

  // Stage register: advance, insert a bubble, or freeze.
  always_comb begin
    // NOTE: the default assignment first guarantees every path assigns stage_d, so no latch is inferred.
    stage_d = stage_q;
    if (!stall[3]) begin
      stage_d = ex_to_mem_bus;
    end else if (!stall[4]) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign is_load = stage_q.data_ram_en && (stage_q.data_ram_wen == 4'b0000);

  function automatic logic [31:0] load_result(input logic [2:0]  op,
                                              input logic [1:0]  addr,
                                              input logic [31:0] d);
    logic [7:0]  lane;
    logic [15:0] half;
    case (addr)
      2'd0:    lane = d[7:0];
      2'd1:    lane = d[15:8];
      2'd2:    lane = d[23:16];
      default: lane = d[31:24];
    endcase
    half = addr[1] ? d[31:16] : d[15:0];
    case (op)
      OP_LB:   load_result = {{24{lane[7]}}, lane};
      OP_LBU:  load_result = {24'd0, lane};
      OP_LH:   load_result = {{16{half[15]}}, half};
      OP_LHU:  load_result = {16'd0, half};
      default: load_result = d;
    endcase
  endfunction

`ifdef MEM_WAIT_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } wait_state_e;

  wait_state_e state_q, state_d;
  logic [31:0] hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (is_load) begin
          if (!data_sram_rvalid) begin
            state_d = S_WAIT;
          end else if (stall[4]) begin
            state_d = S_HOLD;
          end
        end
      end
      S_WAIT: begin
        if (data_sram_rvalid) begin
          state_d = stall[4] ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        if (!stall[4]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // The SRAM bus may change once rvalid drops, so keep the returned word while MEM is frozen.
    if ((state_d == S_HOLD) && (state_q != S_HOLD)) begin
      hold_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign load_data = (state_q == S_HOLD) ? hold_q : data_sram_rdata;
  assign stall_req = ((state_q == S_IDLE) && is_load && !data_sram_rvalid) ||
                     ((state_q == S_WAIT) && !data_sram_rvalid);
`else
  assign load_data = data_sram_rdata;
  assign stall_req = 1'b0;
`endif

  assign unused_bits = ^{stall[5], stall[2:0], data_sram_rvalid};

  assign rf_wdata = (is_load && stage_q.sel_rf_res)
                    ? load_result(stage_q.load_op, stage_q.ex_result[1:0], load_data)
                    : stage_q.ex_result;
  // A pending load must not be written back or forwarded.
  assign rf_we    = stage_q.rf_we && !stall_req;

  assign mem_to_wb_bus    = {stage_q.pc, rf_we, stage_q.rf_waddr, rf_wdata};
  assign mem_to_rf_bus    = {rf_we, stage_q.rf_waddr, rf_wdata};
  assign stallreq_for_mem = stall_req;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic against a reference model.
// Wait-handshake scenarios are compiled only when MEM_WAIT_EN is defined.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [78:0] ex_bus;
  logic [31:0] rdata;
  logic        rvalid;
  logic [69:0] wb;
  logic [37:0] rf;
  logic        sreq;

  int n_cmp = 0;
  int n_err = 0;

  logic [78:0] m_reg;
  bit          m_hold;
  logic [31:0] m_hold_data;

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .ex_to_mem_bus    (ex_bus),
    .data_sram_rdata  (rdata),
    .data_sram_rvalid (rvalid),
    .mem_to_wb_bus    (wb),
    .mem_to_rf_bus    (rf),
    .stallreq_for_mem (sreq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [78:0] mk(input logic [31:0] pc, input logic en, input logic [3:0] wen,
                                     input logic [2:0] op, input logic sel, input logic we,
                                     input logic [4:0] wa, input logic [31:0] res);
    return {pc, en, wen, op, sel, we, wa, res};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] b, h;
    int shift;
    shift = 8 * int'(a);
    b = (d >> shift) & 32'hFF;
    h = a[1] ? (d >> 16) : (d & 32'hFFFF);
    case (op)
      3'd1:    return (b > 32'd127) ? b + 32'hFFFF_FF00 : b;
      3'd2:    return b;
      3'd3:    return (h > 32'h7FFF) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      default: return d;
    endcase
  endfunction

  function automatic bit m_is_load();
    return (m_reg[46] == 1'b1) && (m_reg[45:42] == 4'd0);
  endfunction

  function automatic bit model_stallreq();
`ifdef MEM_WAIT_EN
    return m_is_load() && !rvalid && !m_hold;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic        e_sreq, e_we;
    logic [31:0] eff, e_wdata;
    e_sreq  = model_stallreq();
    eff     = m_hold ? m_hold_data : rdata;
    e_wdata = (m_is_load() && m_reg[38]) ? ref_load(m_reg[41:39], m_reg[1:0], eff) : m_reg[31:0];
    e_we    = m_reg[37] && !e_sreq;
    check("wb_bus", wb, {m_reg[78:47], e_we, m_reg[36:32], e_wdata});
    check("rf_bus", 70'(rf), 70'({e_we, m_reg[36:32], e_wdata}));
    check("stallreq", 70'(sreq), 70'(e_sreq));
  endtask

  task automatic drive(input logic [5:0] s, input logic [78:0] b, input logic [31:0] d, input logic v);
    stall  = s;
    ex_bus = b;
    rdata  = d;
    rvalid = v;
    #1;
    check_model();
  endtask

  task automatic model_update();
`ifdef MEM_WAIT_EN
    if (!m_hold) begin
      if (m_is_load() && rvalid && stall[4]) begin
        m_hold      = 1'b1;
        m_hold_data = rdata;
      end
    end else if (!stall[4]) begin
      m_hold = 1'b0;
    end
`endif
    if (!stall[3]) m_reg = ex_bus;
    else if (!stall[4]) m_reg = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp24 [4];
    exp24[0] = 32'hFFFF_FF80;
    exp24[1] = 32'h0000_0080;
    exp24[2] = 32'hFFFF_80FF;
    exp24[3] = 32'h0000_80FF;

    rst = 1'b0; stall = '0; ex_bus = '0; rdata = '0; rvalid = 1'b0;
    m_reg = '0; m_hold = 1'b0; m_hold_data = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_wb", wb, 70'd0);
    check("rst_rf", 70'(rf), 70'd0);
    check("rst_sreq", 70'(sreq), 70'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // LW with data returned in the same cycle
    drive(6'b0, mk(32'h100, 1'b1, 4'd0, 3'd0, 1'b1, 1'b1, 5'd3, 32'h1000), 32'h0, 1'b0);
    tick();
    drive(6'b0, '0, 32'hDEAD_BEEF, 1'b1);
    check("lw_wdata", 70'(wb[31:0]), 70'(32'hDEAD_BEEF));
    check("lw_sreq", 70'(sreq), 70'd0);
    tick();

    // Sub-word loads on lane 3 / upper half
    for (int i = 0; i < 4; i++) begin
      drive(6'b0, mk(32'h200 + 32'(i), 1'b1, 4'd0, 3'(i + 1), 1'b1, 1'b1, 5'd4,
                     (i < 2) ? 32'h2003 : 32'h2002), 32'h80FF_0000, 1'b1);
      if (i > 0) check("subword", 70'(wb[31:0]), 70'(exp24[i-1]));
      tick();
    end
    drive(6'b0, '0, 32'h80FF_0000, 1'b1);
    check("subword_lhu", 70'(wb[31:0]), 70'(exp24[3]));
    tick();

    // Bubble and hold behaviour of the stage register
    drive(6'b0, mk(32'h300, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 5'd7, 32'h55AA), 32'h0, 1'b0);
    tick();
    drive(6'b001000, mk(32'h3F0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 5'd8, 32'h9999), 32'h0, 1'b0);
    check("pre_bubble", wb, {32'h300, 1'b1, 5'd7, 32'h55AA});
    tick();
    drive(6'b0, mk(32'h304, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 5'd9, 32'h1234), 32'h0, 1'b0);
    check("bubble", wb, 70'd0);
    tick();
    drive(6'b011000, mk(32'h3F4, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 5'd1, 32'hAAAA), 32'h0, 1'b0);
    tick();
    drive(6'b011000, mk(32'h3F8, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 5'd2, 32'hBBBB), 32'h0, 1'b0);
    check("held", wb, {32'h304, 1'b1, 5'd9, 32'h1234});
    tick();
    drive(6'b0, '0, 32'h0, 1'b0);
    tick();

`ifdef MEM_WAIT_EN
    // Three-cycle wait on rvalid
    drive(6'b0, mk(32'h400, 1'b1, 4'd0, 3'd0, 1'b1, 1'b1, 5'd9, 32'h3000), 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(6'b011111, '0, 32'h0, 1'b0);
      check("wait_sreq", 70'(sreq), 70'd1);
      check("wait_wb_we", 70'(wb[37]), 70'd0);
      check("wait_rf_we", 70'(rf[37]), 70'd0);
      tick();
    end
    drive(6'b0, '0, 32'h1234_5678, 1'b1);
    check("wait_data", 70'(wb[31:0]), 70'(32'h1234_5678));
    check("wait_done_we", 70'(wb[37]), 70'd1);
    check("wait_done_sreq", 70'(sreq), 70'd0);
    tick();

    // Data arrives while MEM is stalled: held value survives the bus changing
    drive(6'b0, mk(32'h500, 1'b1, 4'd0, 3'd0, 1'b1, 1'b1, 5'd10, 32'h4000), 32'h0, 1'b0);
    tick();
    drive(6'b011111, '0, 32'hCAFE_F00D, 1'b1);
    check("hold_arrive", 70'(wb[31:0]), 70'(32'hCAFE_F00D));
    check("hold_sreq", 70'(sreq), 70'd0);
    tick();
    drive(6'b011111, '0, 32'h0, 1'b0);
    check("hold_kept", 70'(wb[31:0]), 70'(32'hCAFE_F00D));
    tick();
    drive(6'b0, '0, 32'h0, 1'b0);
    check("hold_release", 70'(wb[31:0]), 70'(32'hCAFE_F00D));
    tick();
    drive(6'b0, '0, 32'h0, 1'b0);
    check("after_hold", wb, 70'd0);
    tick();

    // Reset while waiting, then a stray rvalid
    drive(6'b0, mk(32'h600, 1'b1, 4'd0, 3'd0, 1'b1, 1'b1, 5'd11, 32'h5000), 32'h0, 1'b0);
    tick();
    drive(6'b011111, '0, 32'h0, 1'b0);
    tick();
    drive(6'b011111, '0, 32'h0, 1'b0);
    #2 rst = 1'b1;
    m_reg = '0; m_hold = 1'b0;
    #1;
    check("rst_wait_wb", wb, 70'd0);
    check("rst_wait_rf", 70'(rf), 70'd0);
    check("rst_wait_sreq", 70'(sreq), 70'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(6'b0, '0, 32'h7777_7777, 1'b1);
    check("stray_sreq", 70'(sreq), 70'd0);
    check("stray_wb", wb, 70'd0);
    tick();
    drive(6'b0, '0, 32'h0, 1'b0);
    check("stray_after", wb, 70'd0);
    tick();
`endif

    // Randomized traffic; a model-predicted stall request freezes EX and MEM like the hazard unit would
    for (int n = 0; n < 400; n++) begin
      logic [78:0] b;
      logic [31:0] d;
      logic [5:0]  s;
      logic        v;
      int          k;
      b = mk($urandom, $urandom_range(0, 3) != 0,
             ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0,
             3'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom);
      d = $urandom;
      v = $urandom_range(0, 3) != 0;
      k = int'($urandom_range(0, 9));
      s = (k < 6) ? 6'b000000 : (k == 6) ? 6'b000111 : (k == 7) ? 6'b001111 :
          (k == 8) ? 6'b011111 : 6'b111111;
      rvalid = v;
      if (model_stallreq()) s = 6'b011111;
      drive(s, b, d, v);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port stall  input  `StallBus (6)  pipeline stall vector; bit 3 = EX, bit 4 = MEM, `Stop=1, `NoStop=0.
REQ-004 SHALL have port ex_to_mem_bus  input  79  fields: pc[78:47], data_ram_en[46], data_ram_wen[45:42], load_op[41:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0].
REQ-005 SHALL have port data_sram_rdata  input  32  data SRAM read data.
REQ-006 SHALL have port data_sram_rvalid  input  1  read data valid; used only when MEM_WAIT_EN is defined.
REQ-007 SHALL have port mem_to_wb_bus  output  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
REQ-008 SHALL have port mem_to_rf_bus  output  38  forwarding {we[37], waddr[36:32], wdata[31:0]}.
REQ-009 SHALL have port stallreq_for_mem  output  1  request to freeze stages 0..4 while load data is pending.

Function
REQ-010 Pipeline register SHALL load ex_to_mem_bus when stall[3]=0; SHALL load all-zero (bubble) when stall[3]=1 and stall[4]=0; SHALL hold when stall[3]=1 and stall[4]=1.
REQ-011 A load is defined as registered data_ram_en=1 and data_ram_wen=4'b0000; stores and non-memory ops SHALL pass ex_result as rf_wdata.
REQ-012 Load result SHALL be selected by load_op with byte address ex_result[1:0], little-endian lane k = rdata[8k+7:8k]: 000 LW word; 001 LB sign-extended lane; 010 LBU zero-extended lane; 011 LH half ex_result[1] sign-extended; 100 LHU zero-extended; 101-111 treated as LW.
REQ-013 rf_wdata SHALL be the load result when sel_rf_res=1, else ex_result.
REQ-014 mem_to_wb_bus and mem_to_rf_bus SHALL be combinational from the registered stage and captured data (zero added latency).
REQ-015 Wait FSM states: IDLE, WAIT, HOLD. IDLE->WAIT when a load is registered and rvalid=0; IDLE->HOLD when load, rvalid=1 and stall[4]=1; WAIT->HOLD when rvalid=1 and stall[4]=1; WAIT->IDLE when rvalid=1 and stall[4]=0; HOLD->IDLE when stall[4]=0.
REQ-016 On entering HOLD, data_sram_rdata SHALL be captured into a 32-bit hold register; in HOLD the load result SHALL use the hold register, not the SRAM bus.
REQ-017 stallreq_for_mem SHALL be 1 iff (IDLE with a registered load and rvalid=0) or WAIT; it SHALL be 0 in the cycle rvalid arrives.
REQ-018 While stallreq_for_mem=1, mem_to_rf_bus we SHALL be 0 and mem_to_wb_bus rf_we SHALL be 0.
REQ-019 rvalid arriving while no load is registered SHALL be ignored.

Reset
REQ-020 rst=1 SHALL asynchronously clear the pipeline register, hold register and FSM (to IDLE); mem_to_wb_bus=0, mem_to_rf_bus=0, stallreq_for_mem=0.
REQ-021 rst asserted mid-WAIT SHALL abandon the pending load; a later stray rvalid SHALL be ignored per REQ-019.

Configuration
REQ-022 Macro MEM_WAIT_EN: defined -> REQ-015..REQ-019 active; undefined -> FSM and hold register absent, data_sram_rdata is treated as valid in the MEM cycle, stallreq_for_mem tied 0, data_sram_rvalid unused.

Verification
REQ-023 LW, ex_result=0x1000, rdata=0xDEADBEEF, rvalid=1 -> mem_to_wb_bus rf_wdata=0xDEADBEEF same cycle, stallreq=0.
REQ-024 LB addr[1:0]=2'b11, rdata=0x80FF_0000 -> 0xFFFFFF80; LBU -> 0x00000080; LH addr[1]=1 -> 0xFFFF80FF; LHU -> 0x000080FF.
REQ-025 MEM_WAIT_EN: LW, rvalid low 3 cycles then high with 0x12345678 -> stallreq=1 for exactly 3 cycles, rf_we=0 during them, then rf_wdata=0x12345678, rf_we=1.
REQ-026 MEM_WAIT_EN: rvalid with 0xCAFEF00D while stall[4]=1, SRAM bus changes to 0 next cycle -> HOLD, output stays 0xCAFEF00D until stall[4]=0.
REQ-027 stall[3]=1, stall[4]=0 -> next cycle mem_to_wb_bus=0; stall[3]=stall[4]=1 -> outputs unchanged.
REQ-028 rst pulsed during WAIT -> all outputs 0 immediately; following rvalid=1 with no load -> stallreq stays 0, outputs stay 0.
